// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle RV32 core (lw, sw, R/I ALU, beq, jal).
// Shares one memory port through a req/ready handshake with a bounded wait.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam int unsigned LIMIT_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             stall_st;
  logic             timeout;
  logic             f3_alu_ok;
  logic [2:0]       alu_dec;

  assign stall_st  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout   = (WAIT_LIMIT != 0) && stall_st && !mem_ready
                     && (wait_cnt == CNT_W'(LIMIT_M1));
  assign f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010)
                     || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign state     = state_q;

  // ALU operation decoded from funct3 (sub only for R-type with funct7[5])
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
                  else if (timeout) state_d = S_TRAP;
      S_DECODE: begin
        state_d = S_TRAP;
        case (op)
          OP_LOAD, OP_STORE: if (funct3 == 3'b010) state_d = S_MEMADR;
          OP_RTYPE:          if (f3_alu_ok) state_d = S_EXECR;
          OP_ITYPE:          if (f3_alu_ok) state_d = S_EXECI;
          OP_BR:             if (funct3 == 3'b000) state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
                  else if (timeout) state_d = S_TRAP;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
                  else if (timeout) state_d = S_TRAP;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Wait counter: counts consecutive stalled cycles within one access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (stall_st && !mem_ready && (state_d == state_q))
      wait_cnt <= wait_cnt + CNT_W'(1);
    else
      wait_cnt <= '0;
  end

  // Sticky trap flag; cause distinguishes decode failure from memory timeout
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else if ((state_q != S_TRAP) && (state_d == S_TRAP)) begin
      trap       <= 1'b1;
      trap_cause <= (state_q == S_DECODE) ? 2'b01 : 2'b10;
    end
  end

  // Moore output decode; memory request and fetch writes drop during reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    result_src = 2'b00;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = reset;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready && reset;
        pc_write   = mem_ready && reset;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = reset;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = reset;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = alu_dec;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_dec;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_SUB;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = 2'b11;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default instance plus a WAIT_LIMIT=4 instance.
module tb_multicycle_controller;

  logic       clock, reset;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic       zero, mem_ready;

  logic       d_req, d_wr, d_adr, d_pcw, d_irw, d_rw, d_done, d_trap;
  logic [1:0] d_a, d_b, d_imm, d_res, d_cause;
  logic [2:0] d_alu;
  logic [3:0] d_state;

  logic       t_req, t_wr, t_adr, t_pcw, t_irw, t_rw, t_done, t_trap;
  logic [1:0] t_a, t_b, t_imm, t_res, t_cause;
  logic [2:0] t_alu;
  logic [3:0] t_state;

  int checks = 0;
  int errors = 0;

  multicycle_controller u_dut (
    .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(d_req), .mem_write(d_wr),
    .adr_src(d_adr), .pc_write(d_pcw), .ir_write(d_irw), .reg_write(d_rw),
    .alu_src_a(d_a), .alu_src_b(d_b), .imm_src(d_imm), .result_src(d_res),
    .alu_op(d_alu), .instr_done(d_done), .trap(d_trap), .trap_cause(d_cause),
    .state(d_state)
  );

  multicycle_controller #(.WAIT_LIMIT(4)) u_tmo (
    .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(t_req), .mem_write(t_wr),
    .adr_src(t_adr), .pc_write(t_pcw), .ir_write(t_irw), .reg_write(t_rw),
    .alu_src_a(t_a), .alu_src_b(t_b), .imm_src(t_imm), .result_src(t_res),
    .alu_op(t_alu), .instr_done(t_done), .trap(t_trap), .trap_cause(t_cause),
    .state(t_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then set this cycle's inputs and let outputs settle
  task automatic go(input logic rdy, input logic z);
    @(posedge clock);
    #1;
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op     = o;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // FETCH(ready) -> DECODE -> EXEC -> ALUWB -> FETCH, checking exec state and alu_op
  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] exp_st,
                         input logic [2:0] exp_alu);
    set_instr(o, f3, f7);
    go(1'b1, 1'b0);
    chk({tag, "_decode"}, d_state, 4'd1);
    go(1'b1, 1'b0);
    chk({tag, "_exec_state"}, d_state, exp_st);
    chk({tag, "_alu_op"}, 4'(d_alu), 4'(exp_alu));
    go(1'b1, 1'b0);
    chk({tag, "_aluwb"}, d_state, 4'd8);
    go(1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    #2;
    chk("rst_state", d_state, 4'd0);
    chk("rst_trap", 4'(d_trap), 4'd0);
    chk("rst_cause", 4'(d_cause), 4'd0);
    chk("rst_mem_req", 4'(d_req), 4'd0);

    // add: FETCH, DECODE, EXECR, ALUWB
    @(posedge clock);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("add_fetch_state", d_state, 4'd0);
    chk("add_fetch_req", 4'(d_req), 4'd1);
    chk("add_fetch_irw", 4'(d_irw), 4'd1);
    chk("add_fetch_pcw", 4'(d_pcw), 4'd1);
    chk("add_fetch_b", 4'(d_b), 4'd2);
    chk("add_fetch_res", 4'(d_res), 4'd2);
    chk("add_fetch_rw", 4'(d_rw), 4'd0);
    go(1'b1, 1'b0);
    chk("add_dec_state", d_state, 4'd1);
    chk("add_dec_a", 4'(d_a), 4'd1);
    chk("add_dec_imm", 4'(d_imm), 4'd2);
    chk("add_dec_req", 4'(d_req), 4'd0);
    go(1'b1, 1'b0);
    chk("add_exec_state", d_state, 4'd6);
    chk("add_exec_alu", 4'(d_alu), 4'd0);
    chk("add_exec_a", 4'(d_a), 4'd2);
    chk("add_exec_rw", 4'(d_rw), 4'd0);
    go(1'b1, 1'b0);
    chk("add_wb_state", d_state, 4'd8);
    chk("add_wb_rw", 4'(d_rw), 4'd1);
    chk("add_wb_done", 4'(d_done), 4'd1);
    go(1'b1, 1'b0);
    chk("add_next_fetch", d_state, 4'd0);
    chk("add_fetch_done", 4'(d_done), 4'd0);

    run_alu("sub",  7'b0110011, 3'b000, 7'b0100000, 4'd6, 3'b001);
    run_alu("addi", 7'b0010011, 3'b000, 7'b0100000, 4'd7, 3'b000);
    run_alu("slt",  7'b0110011, 3'b010, 7'b0000000, 4'd6, 3'b101);
    run_alu("ori",  7'b0010011, 3'b110, 7'b0000000, 4'd7, 3'b011);
    run_alu("and",  7'b0110011, 3'b111, 7'b0000000, 4'd6, 3'b010);

    // lw with three stall cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    chk("lw_memadr_state", d_state, 4'd2);
    chk("lw_memadr_imm", 4'(d_imm), 4'd0);
    chk("lw_memadr_b", 4'(d_b), 4'd1);
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b0);
      chk("lw_stall_state", d_state, 4'd3);
      chk("lw_stall_req", 4'(d_req), 4'd1);
      chk("lw_stall_adr", 4'(d_adr), 4'd1);
    end
    go(1'b1, 1'b0);
    chk("lw_read_state", d_state, 4'd3);
    chk("lw_read_req", 4'(d_req), 4'd1);
    go(1'b1, 1'b0);
    chk("lw_wb_state", d_state, 4'd4);
    chk("lw_wb_res", 4'(d_res), 4'd1);
    chk("lw_wb_rw", 4'(d_rw), 4'd1);
    chk("lw_wb_done", 4'(d_done), 4'd1);
    go(1'b1, 1'b0);
    chk("lw_next_fetch", d_state, 4'd0);

    // sw
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    chk("sw_memadr_imm", 4'(d_imm), 4'd1);
    go(1'b1, 1'b0);
    chk("sw_write_state", d_state, 4'd5);
    chk("sw_write_wr", 4'(d_wr), 4'd1);
    chk("sw_write_done", 4'(d_done), 4'd1);
    go(1'b1, 1'b0);
    chk("sw_next_fetch", d_state, 4'd0);

    // beq taken, then not taken
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    go(1'b1, 1'b0);
    go(1'b1, 1'b1);
    chk("beq_t_state", d_state, 4'd9);
    chk("beq_t_pcw", 4'(d_pcw), 4'd1);
    chk("beq_t_alu", 4'(d_alu), 4'd1);
    chk("beq_t_done", 4'(d_done), 4'd1);
    go(1'b1, 1'b0);
    chk("beq_t_fetch", d_state, 4'd0);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    chk("beq_nt_pcw", 4'(d_pcw), 4'd0);
    go(1'b1, 1'b0);
    chk("beq_nt_fetch", d_state, 4'd0);

    // jal
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    chk("jal_state", d_state, 4'd10);
    chk("jal_pcw", 4'(d_pcw), 4'd1);
    chk("jal_imm", 4'(d_imm), 4'd3);
    chk("jal_b", 4'(d_b), 4'd2);
    go(1'b1, 1'b0);
    chk("jal_aluwb", d_state, 4'd8);
    go(1'b1, 1'b0);

    // reset mid-access drops mem_req immediately
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    go(1'b0, 1'b0);
    chk("rmid_memread", d_state, 4'd3);
    reset = 1'b0;
    #1;
    chk("rmid_req", 4'(d_req), 4'd0);
    chk("rmid_state", d_state, 4'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // illegal opcode traps and stays there
    set_instr(7'b1110011, 3'b000, 7'b0000000);
    mem_ready = 1'b1;
    #1;
    go(1'b1, 1'b0);
    chk("ill_decode", d_state, 4'd1);
    go(1'b1, 1'b0);
    chk("ill_state", d_state, 4'd11);
    chk("ill_trap", 4'(d_trap), 4'd1);
    chk("ill_cause", 4'(d_cause), 4'd1);
    for (int i = 0; i < 20; i++) begin
      go(1'(i % 2), 1'b0);
      chk("ill_hold_req", 4'(d_req), 4'd0);
      chk("ill_hold_state", d_state, 4'd11);
    end
    do_reset();
    mem_ready = 1'b0;
    #1;
    chk("ill_rst_state", d_state, 4'd0);
    chk("ill_rst_trap", 4'(d_trap), 4'd0);

    // illegal R-type funct3
    set_instr(7'b0110011, 3'b001, 7'b0000000);
    mem_ready = 1'b1;
    #1;
    go(1'b1, 1'b0);
    go(1'b1, 1'b0);
    chk("f3_trap_state", d_state, 4'd11);
    chk("f3_trap_cause", 4'(d_cause), 4'd1);

    // timeout: four stalled fetch cycles trap the WAIT_LIMIT=4 instance
    do_reset();
    mem_ready = 1'b0;
    #1;
    chk("to_c1", t_state, 4'd0);
    for (int i = 0; i < 3; i++) go(1'b0, 1'b0);
    chk("to_c4_state", t_state, 4'd0);
    chk("to_c4_req", 4'(t_req), 4'd1);
    go(1'b0, 1'b0);
    chk("to_c5_state", t_state, 4'd11);
    chk("to_c5_trap", 4'(t_trap), 4'd1);
    chk("to_c5_cause", 4'(t_cause), 4'd2);
    chk("to_c5_req", 4'(t_req), 4'd0);
    chk("to_dflt_state", d_state, 4'd0);
    chk("to_dflt_trap", 4'(d_trap), 4'd0);

    // ready on the fourth stall cycle wins over the limit
    do_reset();
    mem_ready = 1'b0;
    #1;
    go(1'b0, 1'b0);
    go(1'b0, 1'b0);
    go(1'b1, 1'b0);
    chk("rdy_c4_irw", 4'(t_irw), 4'd1);
    go(1'b1, 1'b0);
    chk("rdy_c5_state", t_state, 4'd1);
    chk("rdy_c5_trap", 4'(t_trap), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
